// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a - b - bin over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             d;
  logic             br_next;
  logic             accept;
  logic             last;
  logic             sr_d;
  logic             dv_d;

  assign accept = (state == IDLE) & start_valid & start_ready;
  assign last   = (state == RUN) & (cnt == CW'(WIDTH - 1));

  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (done_valid & done_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_comb begin
    sr_d = (nxt == IDLE);
    dv_d = (nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ready <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      start_ready <= sr_d;
      done_valid  <= dv_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_next;
      res <= {d, res[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= {d, res[WIDTH-1:1]};
        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // On the last step sa[0]/sb[0] hold the operand MSBs
        ovf  <= (sa[0] ^ sb[0]) & (d ^ sa[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Overflow checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;

  logic       sv4 = 1'b0;
  logic       sr4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       dv4;
  logic       dr4 = 1'b0;
  logic [3:0] d4;
  logic       bo4;

  logic       sv8 = 1'b0;
  logic       sr8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       dv8;
  logic       dr8 = 1'b0;
  logic [7:0] d8;
  logic       bo8;

`ifdef SERIAL_SUB_OVF_EN
  logic       ov4;
  logic       ov8;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .bin(bin4),
    .done_valid(dv4), .done_ready(dr4),
    .diff(d4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ov4),
`endif
    .bout(bo4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8),
    .done_valid(dv8), .done_ready(dr8),
    .diff(d8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ov8),
`endif
    .bout(bo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for start_ready, present operands, return after the accept edge
  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic bi);
    int k = 0;
    while (!sr4 && k < 50) begin
      tick();
      k++;
    end
    total++;
    if (!sr4) begin
      bad++;
      $display("FAIL issue4_ready: start_ready=%b required 1", sr4);
    end
    a4 = a; b4 = b; bin4 = bi; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    a4 = 4'hx; b4 = 4'hx; bin4 = 1'bx;
  endtask

  task automatic wait_done4(output int lat);
    lat = 0;
    while (!dv4 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if ({sr4, dv4, d4, bo4} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs: sr=%b dv=%b diff=%h bout=%b required 0",
               sr4, dv4, d4, bo4);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ov4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: ovf=%b required 0", ov4);
    end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (sr4 !== 1'b1 || dv4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: sr=%b dv=%b required 1/0", sr4, dv4);
    end
  endtask

  task automatic test_basic();
    int lat;
    dr4 = 1'b1;
    issue4(4'd7, 4'd3, 1'b0);
    wait_done4(lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d required 4", lat);
    end
    total++;
    if (d4 !== 4'd4 || bo4 !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: diff=%h bout=%b required 4/0", d4, bo4);
    end
    tick();
    total++;
    if (dv4 !== 1'b0 || sr4 !== 1'b1) begin
      bad++;
      $display("FAIL basic_one_cycle_done: dv=%b sr=%b required 0/1",
               dv4, sr4);
    end
  endtask

  task automatic test_borrow();
    logic [3:0] va [2] = '{4'd3, 4'd0};
    logic [3:0] vb [2] = '{4'd5, 4'd0};
    logic       vi [2] = '{1'b0, 1'b1};
    logic [3:0] ed [2] = '{4'hE, 4'hF};
    int lat;
    dr4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue4(va[i], vb[i], vi[i]);
      wait_done4(lat);
      total++;
      if (dv4 !== 1'b1 || d4 !== ed[i] || bo4 !== 1'b1) begin
        bad++;
        $display("FAIL borrow_%0d: dv=%b diff=%h bout=%b required 1/%h/1",
                 i, dv4, d4, bo4, ed[i]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    dr4 = 1'b0;
    issue4(4'd5, 4'd2, 1'b0);
    wait_done4(lat);
    for (int i = 0; i < 3; i++) begin
      sv4 = (i == 0);
      a4 = 4'd9; b4 = 4'd1; bin4 = 1'b0;
      total++;
      if (dv4 !== 1'b1 || d4 !== 4'd3 || bo4 !== 1'b0 || sr4 !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: dv=%b diff=%h bout=%b sr=%b req 1/3/0/0",
                 i, dv4, d4, bo4, sr4);
      end
      tick();
    end
    sv4 = 1'b0;
    total++;
    if (dv4 !== 1'b1 || d4 !== 4'd3) begin
      bad++;
      $display("FAIL bp_still: dv=%b diff=%h required 1/3", dv4, d4);
    end
    dr4 = 1'b1;
    tick();
    total++;
    if (dv4 !== 1'b0 || sr4 !== 1'b1 || d4 !== 4'd3) begin
      bad++;
      $display("FAIL bp_release: dv=%b sr=%b diff=%h required 0/1/3",
               dv4, sr4, d4);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen = 1'b0;
    dr4 = 1'b1;
    issue4(4'd9, 4'd2, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({sr4, dv4, d4, bo4} !== 7'b0) begin
      bad++;
      $display("FAIL midrst_outs: sr=%b dv=%b diff=%h bout=%b required 0",
               sr4, dv4, d4, bo4);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dv4 === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || sr4 !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after: done_seen=%b sr=%b required 0/1",
               seen, sr4);
    end
    issue4(4'd6, 4'd6, 1'b0);
    wait_done4(lat);
    total++;
    if (dv4 !== 1'b1 || d4 !== 4'd0 || bo4 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_next: dv=%b diff=%h bout=%b required 1/0/0",
               dv4, d4, bo4);
    end
    tick();
  endtask

  task automatic test_ovf();
`ifdef SERIAL_SUB_OVF_EN
    int lat;
    dr4 = 1'b1;
    issue4(4'h8, 4'h1, 1'b0);
    wait_done4(lat);
    total++;
    if (d4 !== 4'h7 || ov4 !== 1'b1 || bo4 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_set: diff=%h ovf=%b bout=%b required 7/1/0",
               d4, ov4, bo4);
    end
    tick();
    issue4(4'h2, 4'h1, 1'b0);
    wait_done4(lat);
    total++;
    if (d4 !== 4'h1 || ov4 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: diff=%h ovf=%b required 1/0", d4, ov4);
    end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    int       prev_acc = 0;
    int       acc;
    int       cyc = 0;
    int       k;
    int       lat;
    logic [8:0] full;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ei;
    dr8 = 1'b1;
    sv8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      while (!sr8 && k < 50) begin
        tick();
        cyc++;
        k++;
      end
      ea = 8'($urandom);
      eb = 8'($urandom);
      ei = 1'($urandom);
      a8 = ea; b8 = eb; bin8 = ei;
      tick();
      cyc++;
      acc = cyc;
      if (i > 0) begin
        total++;
        if (acc - prev_acc !== 10) begin
          bad++;
          $display("FAIL b2b_interval_%0d: got %0d required 10",
                   i, acc - prev_acc);
        end
      end
      prev_acc = acc;
      lat = 0;
      while (!dv8 && lat < 50) begin
        tick();
        cyc++;
        lat++;
      end
      full = {1'b0, ea} - {1'b0, eb} - {8'd0, ei};
      total++;
      if (lat !== 8 || d8 !== full[7:0] || bo8 !== full[8]) begin
        bad++;
        $display("FAIL b2b_result_%0d: a=%h b=%h bin=%b lat=%0d diff=%h bout=%b required 8/%h/%b",
                 i, ea, eb, ei, lat, d8, bo8, full[7:0], full[8]);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ov8 !== ((ea[7] ^ eb[7]) & (full[7] ^ ea[7]))) begin
        bad++;
        $display("FAIL b2b_ovf_%0d: ovf=%b", i, ov8);
      end
`endif
    end
    sv8 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid();
    test_ovf();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor computing `a - b - bin` over WIDTH clock cycles using a single full-subtractor cell and a borrow flop. It is the inverse-direction companion to the team's ripple adders, for area-constrained datapaths where a combinational borrow chain is too large. Operands are accepted and results returned through valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..32.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  operands a, b and bin are valid.
- `start_ready`  out  1  block can accept operands; reset 0.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `done_valid`  out  1  result valid; reset 0.
- `done_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`; reset 0.
- `bout`  out  1  borrow-out; 1 when `a < b + bin` (unsigned); reset 0.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`; reset 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid & start_ready`: latch `a` and `b` into shift registers, load borrow flop from `bin`, clear the bit counter, go to RUN.
- **RUN**
  - `start_ready` = 0.
  - Each cycle, bit 0 of each shift register feeds the cell:
    - `d = a0 ^ b0 ^ br`
    - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - `d` shifts into the result register at the MSB end. Both operand registers shift right. Counter increments.
  - When the counter reaches WIDTH-1 (last bit processed):
    - copy the completed result to `diff`, and `br_next` to `bout` (and `ovf`);
    - go to DONE.
- **DONE**
  - `done_valid` = 1.
  - `diff`, `bout` and `ovf` are stable.
  - On `done_valid & done_ready`, go to IDLE.
- Outputs `diff`, `bout` and `ovf` hold the last completed result until the next completion. They never show partial results.
- `a`, `b` and `bin` are ignored except on the accept edge.
- `start_valid` asserted in RUN or DONE is not accepted. The producer holds it until `start_ready`.
- Reset mid-operation: the FSM returns to IDLE immediately, all outputs go to 0, and the in-flight operation is discarded with no `done_valid` pulse.

## Timing
- Accept at edge N → RUN from edge N.
- The WIDTH bit-steps occur at edges N+1 .. N+WIDTH.
- `done_valid` rises after edge N+WIDTH. Latency is WIDTH cycles from accept to result.
- DONE → IDLE on the handshake edge. `start_ready` rises the cycle after the handshake.
- Minimum issue interval is WIDTH+2 cycles.
- No combinational path from any input to any output. All outputs are registered.
- `done_ready` may be held high permanently. DONE then lasts exactly one cycle.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - the `ovf` port exists;
  - `ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1])`, computed from the latched operand MSBs;
  - updated with `diff` at completion, held with it, and 0 at reset.
- **Undefined:**
  - no `ovf` port and no operand-MSB storage;
  - all other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=4, a=7, b=3, bin=0, `done_ready`=1 → `done_valid` exactly 4 cycles after accept; `diff`=4, `bout`=0.
- **Borrow:**
  - a=3, b=5, bin=0 → `diff`=0xE, `bout`=1.
  - a=0, b=0, bin=1 → `diff`=0xF, `bout`=1.
- **Back-pressure:** hold `done_ready`=0 for 3 cycles after `done_valid` → `done_valid`, `diff` and `bout` remain constant; `start_ready` stays 0; a `start_valid` pulse during this time is not accepted.
- **Reset mid-run:** assert `rst` 2 cycles after accept (a=9, b=2) → all outputs 0 immediately; `start_ready`=1 after release; no `done_valid` pulse; the next operation, a=6, b=6, gives `diff`=0, `bout`=0.
- **Overflow (`SERIAL_SUB_OVF_EN`):**
  - a=0x8, b=0x1 → `diff`=0x7, `ovf`=1, `bout`=0.
  - a=0x2, b=0x1 → `ovf`=0.
- **Width sweep:** WIDTH=8, 256 random operand pairs issued back-to-back → each result matches `(a-b-bin) mod 256` and the borrow reference model; issue interval is 10 cycles.
